// File: rtl/hours_counter.sv
// rtl/hours_counter.sv - hour-of-day counter with day rollover, manual set and BCD display
// Optional 12-hour display build: define TWELVE_HOUR_EN.
module hours_counter #(
   parameter int MAX_HOUR     = 23,
   parameter int REPEAT_DELAY = 3
) (
   input  logic       clk_1Hz,
   input  logic       rst,
   input  logic       min_tick,
   input  logic       set_mode,
   input  logic       set_inc,
   input  logic       set_dec,
   output logic [4:0] hours,
   output logic [1:0] hours_tens,
   output logic [3:0] hours_units,
   output logic       pm,
   output logic       day_tick,
   output logic       set_active
);

   typedef enum logic [1:0] {RUN, SET, SET_RPT} state_t;

   localparam logic [4:0] MAX_H = 5'(MAX_HOUR);
   localparam logic [3:0] RPT   = 4'(REPEAT_DELAY);
`ifdef TWELVE_HOUR_EN
   localparam logic [1:0] RST_TENS  = 2'd1;
   localparam logic [3:0] RST_UNITS = 4'd2;
`else
   localparam logic [1:0] RST_TENS  = 2'd0;
   localparam logic [3:0] RST_UNITS = 4'd0;
`endif

   state_t     state_q, state_d;
   logic [4:0] hours_q, hours_d;
   logic [3:0] hold_q, hold_d;
   logic       inc_q, dec_q;
   logic       day_tick_q, day_tick_d;
   logic [1:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;
   logic       pm_q, pm_d;
   logic       set_active_q;
   logic       inc_rise, dec_rise;
   logic [4:0] disp;
   logic [4:0] tens_sub;

   assign inc_rise = set_inc & ~inc_q;
   assign dec_rise = set_dec & ~dec_q;

   function automatic logic [4:0] inc_wrap(input logic [4:0] h);
      return (h == MAX_H) ? 5'd0 : h + 5'd1;
   endfunction

   // Decrement from 0 jumps straight to MAX_HOUR so the register never underflows.
   function automatic logic [4:0] dec_wrap(input logic [4:0] h);
      return (h == 5'd0) ? MAX_H : h - 5'd1;
   endfunction

   // Next-state, next-hour and hold-counter logic for the RUN/SET/SET_RPT FSM.
   always_comb begin
      state_d    = state_q;
      hours_d    = hours_q;
      hold_d     = hold_q;
      day_tick_d = 1'b0;
      case (state_q)
         RUN: begin
            hold_d = 4'd0;
            if (min_tick) begin
               if (hours_q == MAX_H) begin
                  hours_d    = 5'd0;
                  day_tick_d = 1'b1;
               end else begin
                  hours_d = hours_q + 5'd1;
               end
            end
            if (set_mode) state_d = SET;
         end
         SET: begin
            if (!set_mode) begin
               state_d = RUN;
               hold_d  = 4'd0;
            end else begin
               if (inc_rise && !dec_rise)      hours_d = inc_wrap(hours_q);
               else if (dec_rise && !inc_rise) hours_d = dec_wrap(hours_q);
               if (set_inc && inc_q) begin
                  if (hold_q < RPT) hold_d = hold_q + 4'd1;
                  if (hold_d == RPT) state_d = SET_RPT;
               end else begin
                  hold_d = 4'd0;
               end
            end
         end
         SET_RPT: begin
            if (!set_mode) begin
               state_d = RUN;
               hold_d  = 4'd0;
            end else if (!set_inc || set_dec) begin
               state_d = SET;
               hold_d  = 4'd0;
            end else begin
               hours_d = inc_wrap(hours_q);
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Display digits are derived from the next hour so they update on the same edge as hours.
   always_comb begin
`ifdef TWELVE_HOUR_EN
      if (hours_d == 5'd0)       disp = 5'd12;
      else if (hours_d > 5'd12)  disp = hours_d - 5'd12;
      else                       disp = hours_d;
      pm_d = (hours_d >= 5'd12);
`else
      disp = hours_d;
      pm_d = 1'b0;
`endif
      if (disp >= 5'd20) begin
         tens_d   = 2'd2;
         tens_sub = 5'd20;
      end else if (disp >= 5'd10) begin
         tens_d   = 2'd1;
         tens_sub = 5'd10;
      end else begin
         tens_d   = 2'd0;
         tens_sub = 5'd0;
      end
      units_d = 4'(disp - tens_sub);
   end

   // State, counters, button history and registered outputs.
   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         state_q      <= RUN;
         hours_q      <= 5'd0;
         hold_q       <= 4'd0;
         inc_q        <= 1'b0;
         dec_q        <= 1'b0;
         day_tick_q   <= 1'b0;
         tens_q       <= RST_TENS;
         units_q      <= RST_UNITS;
         pm_q         <= 1'b0;
         set_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hours_q      <= hours_d;
         hold_q       <= hold_d;
         inc_q        <= set_inc;
         dec_q        <= set_dec;
         day_tick_q   <= day_tick_d;
         tens_q       <= tens_d;
         units_q      <= units_d;
         pm_q         <= pm_d;
         set_active_q <= (state_d != RUN);
      end
   end

   assign hours       = hours_q;
   assign hours_tens  = tens_q;
   assign hours_units = units_q;
   assign pm          = pm_q;
   assign day_tick    = day_tick_q;
   assign set_active  = set_active_q;

endmodule
